// File: rtl/spi_transaction_arbiter_if.sv
// Bus bundle between two SPI requesters, the transaction arbiter and the
// SPI slave pins. The master view belongs to the requesters/slave side,
// the slave view belongs to the arbiter itself.
interface spi_transaction_arbiter_if;
  logic        REQ0;
  logic        REQ1;
  logic [15:0] TX_DATA0;
  logic [15:0] TX_DATA1;
  logic        CKP;
  logic        CPH;
  logic        MISO;
  logic        start_transaction;
  logic        SS;
  logic        SCK;
  logic        MOSI;
  logic [15:0] RX_DATA;
  logic        DONE0;
  logic        DONE1;
  logic        BUSY;

  modport master (
    output REQ0, REQ1, TX_DATA0, TX_DATA1, CKP, CPH, MISO,
    input  start_transaction, SS, SCK, MOSI, RX_DATA, DONE0, DONE1, BUSY
  );

  modport slave (
    input  REQ0, REQ1, TX_DATA0, TX_DATA1, CKP, CPH, MISO,
    output start_transaction, SS, SCK, MOSI, RX_DATA, DONE0, DONE1, BUSY
  );
endinterface

// File: rtl/spi_transaction_arbiter.sv
// Two-requester round-robin arbiter driving a single SPI master port.
// A granted requester gets one full 16-bit frame in the SPI mode it
// presented at grant time; the received word and a one-cycle DONE pulse
// are returned to that requester only.
module spi_transaction_arbiter #(
  parameter int SCK_DIV    = 2,
  parameter int FRAME_BITS = 16
) (
  input logic                    CLK,
  input logic                    RESET_N,
  spi_transaction_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(SCK_DIV - 1);
  localparam logic [5:0] LAST_EDGE  = 6'(2 * FRAME_BITS - 1);

  state_t                state;
  state_t                next_state;
  logic [7:0]            timer;
  logic                  tick;
  logic [5:0]            edge_cnt;
  logic                  leading;
  logic                  sck_q;
  logic                  mosi_q;
  logic                  cph_q;
  logic                  last_grant;
  logic                  grant_idx;
  logic                  any_req;
  logic [FRAME_BITS-1:0] tx_sel;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-1:0] rx_shift;
  logic [FRAME_BITS-1:0] rx_q;

  // On a tie the requester that did not win last time gets the bus.
  assign any_req   = bus.REQ0 | bus.REQ1;
  assign grant_idx = (bus.REQ0 & bus.REQ1) ? ~last_grant : bus.REQ1;
  assign tx_sel    = grant_idx ? bus.TX_DATA1 : bus.TX_DATA0;
  assign tick      = (timer == TIMER_LAST);
  assign leading   = ~edge_cnt[0];
  assign bus.RX_DATA = rx_q;

  // State register; reset aborts any frame in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state selection: timed states advance on the half-period tick.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = SETUP;
      SETUP:   if (tick) next_state = SHIFT;
      SHIFT:   if (tick && (edge_cnt == LAST_EDGE)) next_state = HOLD;
      HOLD:    if (tick) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: grant capture, half-period timer, SCK toggling and both shifters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      timer      <= '0;
      edge_cnt   <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cph_q      <= 1'b0;
      last_grant <= 1'b1;
      tx_shift   <= '0;
      rx_shift   <= '0;
      rx_q       <= '0;
    end else begin
      if ((state == IDLE) || (state == DONE) || tick) timer <= '0;
      else                                             timer <= timer + 8'd1;
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= grant_idx;
            cph_q      <= bus.CPH;
            sck_q      <= bus.CKP;
            edge_cnt   <= '0;
            rx_shift   <= '0;
            if (!bus.CPH) begin
              mosi_q   <= tx_sel[FRAME_BITS-1];
              tx_shift <= {tx_sel[FRAME_BITS-2:0], 1'b0};
            end else begin
              mosi_q   <= 1'b0;
              tx_shift <= tx_sel;
            end
          end
        end
        SHIFT: begin
          if (tick) begin
            sck_q    <= ~sck_q;
            edge_cnt <= edge_cnt + 6'd1;
            if (leading ^ cph_q) begin
              rx_shift <= {rx_shift[FRAME_BITS-2:0], bus.MISO};
            end else begin
              mosi_q   <= tx_shift[FRAME_BITS-1];
              tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (tick) rx_q <= rx_shift;
        end
        default: begin
        end
      endcase
    end
  end

  // Pin outputs decoded from the state; idle SCK follows the live CKP input.
  always_comb begin
    bus.SS                = 1'b1;
    bus.start_transaction = 1'b0;
    bus.BUSY              = 1'b1;
    bus.DONE0             = 1'b0;
    bus.DONE1             = 1'b0;
    bus.SCK               = sck_q;
    bus.MOSI              = mosi_q;
    case (state)
      IDLE: begin
        bus.BUSY = 1'b0;
        bus.SCK  = bus.CKP & RESET_N;
        bus.MOSI = 1'b0;
      end
      SETUP, SHIFT, HOLD: begin
        bus.SS                = 1'b0;
        bus.start_transaction = 1'b1;
      end
      DONE: begin
        bus.DONE0 = ~last_grant;
        bus.DONE1 = last_grant;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_spi_transaction_arbiter.sv
// Self-checking bench for spi_transaction_arbiter: a directed vector table,
// randomized frames against a round-robin/SPI reference model, a mid-frame
// reset sequence and a fast-clock (SCK_DIV=1) instance.
module tb_spi_transaction_arbiter;

  typedef struct {
    logic        r0;
    logic        r1;
    logic [15:0] t0;
    logic [15:0] t1;
    logic        ckp;
    logic        cph;
    int          miso_sel;
    int          win;
    logic [15:0] rx;
  } vec_t;

  logic        CLK;
  logic        RESET_N;
  logic        req0, req1, reqb0, ckp, cph;
  logic [15:0] tx0, tx1;
  int          miso_sel;
  int          tests;
  int          failed;
  int          model_last;
  vec_t        vecs[8];

  spi_transaction_arbiter_if bus_a();
  spi_transaction_arbiter_if bus_b();

  assign bus_a.REQ0     = req0;
  assign bus_a.REQ1     = req1;
  assign bus_a.TX_DATA0 = tx0;
  assign bus_a.TX_DATA1 = tx1;
  assign bus_a.CKP      = ckp;
  assign bus_a.CPH      = cph;
  assign bus_a.MISO     = (miso_sel == 0) ? bus_a.MOSI : (miso_sel == 1);

  assign bus_b.REQ0     = reqb0;
  assign bus_b.REQ1     = 1'b0;
  assign bus_b.TX_DATA0 = tx0;
  assign bus_b.TX_DATA1 = 16'h0000;
  assign bus_b.CKP      = ckp;
  assign bus_b.CPH      = cph;
  assign bus_b.MISO     = bus_b.MOSI;

  spi_transaction_arbiter #(.SCK_DIV(2), .FRAME_BITS(16)) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus_a)
  );

  spi_transaction_arbiter #(.SCK_DIV(1), .FRAME_BITS(16)) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus_b)
  );

  // Free-running clock; inputs change and outputs are sampled on negedges.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case the sequencing itself gets stuck.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    req0     = v.r0;
    req1     = v.r1;
    tx0      = v.t0;
    tx1      = v.t1;
    ckp      = v.ckp;
    cph      = v.cph;
    miso_sel = v.miso_sel;
  endtask

  // Called on the negedge of the grant cycle (cycle 1); follows the frame,
  // rebuilding the transmitted word from MOSI on each sampling edge.
  task automatic check_frame(input int winner, input logic [15:0] tx,
                             input logic fckp, input logic fcph,
                             input logic [15:0] rx_exp, input int len_exp,
                             input string tag);
    int          n;
    int          edges;
    logic        sck_prev;
    logic        sampling;
    logic [15:0] cap;
    logic        got;
    logic        overlap;
    #1;
    sck_prev = bus_a.SCK;
    n = 1; edges = 0; cap = '0; got = 1'b0; overlap = 1'b0;
    while (!got && (n < 200)) begin
      @(negedge CLK);
      n++;
      if (bus_a.SCK !== sck_prev) begin
        edges++;
        sampling = fcph ? ((edges % 2) == 0) : ((edges % 2) == 1);
        if (sampling) cap = {cap[14:0], bus_a.MOSI};
        sck_prev = bus_a.SCK;
      end
      if (bus_a.DONE0 && bus_a.DONE1) overlap = 1'b1;
      if (bus_a.DONE0 || bus_a.DONE1) got = 1'b1;
    end
    check_output({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check_output({tag, "_done_who"}, {30'd0, bus_a.DONE1, bus_a.DONE0},
                   (winner != 0) ? 32'd2 : 32'd1);
      check_output({tag, "_latency"}, n, len_exp);
      check_output({tag, "_sck_edges"}, edges, 32'd32);
      check_output({tag, "_mosi_bits"}, 32'(cap), 32'(tx));
      check_output({tag, "_rx_data"}, 32'(bus_a.RX_DATA), 32'(rx_exp));
      check_output({tag, "_overlap"}, 32'(overlap), 32'd0);
      check_output({tag, "_sck_idle"}, 32'(bus_a.SCK), 32'(fckp));
      check_output({tag, "_ss_high"}, 32'(bus_a.SS), 32'd1);
    end
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    apply_stimulus(v);
    check_frame(v.win, (v.win != 0) ? v.t1 : v.t0, v.ckp, v.cph, v.rx, 70, tag);
    model_last = v.win;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int          edges;
    int          n;
    logic        sck_prev;
    logic        done_seen;
    vec_t        v;

    tests = 0; failed = 0; model_last = 1;
    RESET_N = 1'b0;
    req0 = 0; req1 = 0; reqb0 = 0; ckp = 0; cph = 0;
    tx0 = '0; tx1 = '0; miso_sel = 0;

    vecs[0] = '{1'b1, 1'b0, 16'h0402, 16'h0000, 1'b0, 1'b0, 0, 0, 16'h0402};
    vecs[1] = '{1'b1, 1'b0, 16'h0402, 16'h0000, 1'b0, 1'b1, 0, 0, 16'h0402};
    vecs[2] = '{1'b1, 1'b0, 16'h0402, 16'h0000, 1'b1, 1'b0, 0, 0, 16'h0402};
    vecs[3] = '{1'b1, 1'b0, 16'h0402, 16'h0000, 1'b1, 1'b1, 0, 0, 16'h0402};
    vecs[4] = '{1'b0, 1'b1, 16'h5555, 16'h0000, 1'b0, 1'b0, 1, 1, 16'hFFFF};
    vecs[5] = '{1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b0, 2, 0, 16'h0000};
    vecs[6] = '{1'b1, 1'b1, 16'h8001, 16'h7FFE, 1'b1, 1'b1, 0, 1, 16'h7FFE};
    vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 0, 1, 16'hFFFF};

    // Reset values while reset is held.
    repeat (3) @(negedge CLK);
    check_output("rst_ss", 32'(bus_a.SS), 32'd1);
    check_output("rst_sck", 32'(bus_a.SCK), 32'd0);
    check_output("rst_mosi", 32'(bus_a.MOSI), 32'd0);
    check_output("rst_start", 32'(bus_a.start_transaction), 32'd0);
    check_output("rst_done", {30'd0, bus_a.DONE1, bus_a.DONE0}, 32'd0);
    check_output("rst_busy", 32'(bus_a.BUSY), 32'd0);
    check_output("rst_rx", 32'(bus_a.RX_DATA), 32'd0);

    // Both requesters held from reset: grants alternate 0,1,0,1.
    RESET_N = 1'b1;
    req0 = 1; req1 = 1; tx0 = 16'hA5C3; tx1 = 16'h3C5A;
    for (int k = 0; k < 4; k++) begin
      check_frame(k % 2, (k % 2) ? tx1 : tx0, 1'b0, 1'b0,
                  (k % 2) ? tx1 : tx0, 70, "rr_held");
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end
      @(negedge CLK);
    end
    model_last = 1;

    // Directed vectors: all four modes, stuck MISO, ties after known history.
    for (int i = 0; i < 8; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // Randomized frames against the round-robin and SPI reference model.
    for (int i = 0; i < 16; i++) begin
      int mask;
      mask       = int'($urandom_range(1, 3));
      v.r0       = (mask & 1) != 0;
      v.r1       = (mask & 2) != 0;
      v.t0       = 16'($urandom);
      v.t1       = 16'($urandom);
      v.ckp      = 1'($urandom);
      v.cph      = 1'($urandom);
      v.miso_sel = int'($urandom_range(0, 2));
      if (mask == 3)      v.win = 1 - model_last;
      else if (mask == 2) v.win = 1;
      else                v.win = 0;
      if (v.miso_sel == 0)      v.rx = (v.win != 0) ? v.t1 : v.t0;
      else if (v.miso_sel == 1) v.rx = 16'hFFFF;
      else                      v.rx = 16'h0000;
      run_vector(v, $sformatf("rand%0d", i));
    end

    // Reset at the tenth SCK edge: everything drops at once, no DONE, restart.
    req0 = 1; tx0 = 16'hF0F0; ckp = 1; cph = 0; miso_sel = 0;
    #1;
    sck_prev = bus_a.SCK; edges = 0; n = 0;
    while ((edges < 10) && (n < 200)) begin
      @(negedge CLK);
      n++;
      if (bus_a.SCK !== sck_prev) begin
        edges++;
        sck_prev = bus_a.SCK;
      end
    end
    check_output("midrst_reach_edge10", edges, 32'd10);
    RESET_N = 1'b0;
    #1;
    check_output("midrst_ss", 32'(bus_a.SS), 32'd1);
    check_output("midrst_sck", 32'(bus_a.SCK), 32'd0);
    check_output("midrst_busy", 32'(bus_a.BUSY), 32'd0);
    check_output("midrst_start", 32'(bus_a.start_transaction), 32'd0);
    check_output("midrst_rx", 32'(bus_a.RX_DATA), 32'd0);
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      done_seen = done_seen | bus_a.DONE0 | bus_a.DONE1;
    end
    check_output("midrst_no_done", 32'(done_seen), 32'd0);
    RESET_N = 1'b1;
    check_frame(0, 16'hF0F0, 1'b1, 1'b0, 16'hF0F0, 70, "midrst_restart");
    req0 = 0;
    @(negedge CLK);

    // SCK_DIV=1 instance: one-cycle half period, 36-cycle frame.
    reqb0 = 1; tx0 = 16'h0402; ckp = 0; cph = 0;
    n = 1;
    done_seen = 1'b0;
    while (!done_seen && (n < 100)) begin
      @(negedge CLK);
      n++;
      done_seen = bus_b.DONE0;
    end
    check_output("div1_done_seen", 32'(done_seen), 32'd1);
    check_output("div1_latency", n, 32'd36);
    check_output("div1_rx", 32'(bus_b.RX_DATA), 32'h0402);
    check_output("div1_done1_low", 32'(bus_b.DONE1), 32'd0);
    reqb0 = 0;
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spi_transaction_arbiter.md
SPI_TRANSACTION_ARBITER -- requirements
Module: spi_transaction_arbiter

Interface
REQ-001 Parameter SCK_DIV, default 2, CLK cycles per SCK half-period (legal 1..255).
REQ-002 Parameter FRAME_BITS, default 16, bits per transaction (fixed 16 in this revision).
REQ-003 CLK  input  1  single system clock; all logic on posedge CLK.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 REQ0, REQ1  input  1 each  transaction request from requester 0/1; level, held until own DONE.
REQ-006 TX_DATA0, TX_DATA1  input  16 each  frame to send, MSB first; sampled at grant.
REQ-007 CKP, CPH  input  1 each  SPI mode (SCK idle level, clock phase); sampled at grant.
REQ-008 MISO  input  1  serial data from slave.
REQ-009 start_transaction  output  1  high from SETUP entry through HOLD, drives slave start input.
REQ-010 SS  output  1  slave select, active low.
REQ-011 SCK  output  1  serial clock.
REQ-012 MOSI  output  1  serial data to slave.
REQ-013 RX_DATA  output  16  last received frame; valid when DONEx pulses, held until next DONE.
REQ-014 DONE0, DONE1  output  1 each  one-CLK completion pulse to requester 0/1.
REQ-015 BUSY  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-017 Half-period timer counts SCK_DIV CLK cycles; "tick" = timer expiry; timer restarts on every state entry.
REQ-018 IDLE: SS=1, SCK=CKP (live input), start_transaction=0, MOSI=0; on any REQx high -> SETUP next cycle.
REQ-019 Arbitration: round-robin; both high -> requester not granted last wins; after reset, requester 0 wins ties.
REQ-020 Grant cycle latches TX_DATAx into shift register, CKP/CPH into mode register, grant index into pointer.
REQ-021 SETUP: SS=0, start_transaction=1, SCK=latched CKP; CPH=0 -> MOSI=bit15 driven on entry; one tick -> SHIFT.
REQ-022 SHIFT: SCK toggles on each tick; exactly 32 edges (16 leading, 16 trailing); edge counter 6 bits.
REQ-023 CPH=0: sample MISO on leading edge, shift MOSI to next bit on trailing edge.
REQ-024 CPH=1: shift MOSI to next bit on leading edge (first leading edge drives bit15), sample MISO on trailing edge.
REQ-025 Received bits shift in LSB-first position, first sampled bit ends in RX_DATA[15].
REQ-026 After 32nd edge SCK = latched CKP; -> HOLD.
REQ-027 HOLD: SS=0, start_transaction=1 for one tick; -> DONE.
REQ-028 DONE: SS=1, start_transaction=0, RX_DATA updated, DONEx=1 for granted x only, one CLK; -> IDLE.
REQ-029 Total frame length = 34*SCK_DIV + 2 CLK cycles from grant to DONE pulse inclusive.
REQ-030 REQx deasserted mid-frame: frame completes normally, DONEx still pulses.
REQ-031 CKP/CPH/TX_DATA changes after grant: no effect until next grant.
REQ-032 Requester re-asserting REQ in cycle after DONE: eligible; round-robin still favors the other if both high.
REQ-033 DONE0 and DONE1 never high simultaneously.

Reset
REQ-034 RESET_N low, any state, immediately: state=IDLE, SS=1, SCK=0, MOSI=0, start_transaction=0, DONE0/1=0, BUSY=0, RX_DATA=0, RR pointer = "last granted 1".
REQ-035 Reset mid-frame: frame aborted, no DONE pulse; after release, pending REQ restarts from SETUP.

Verification
REQ-036 Mode 0, SCK_DIV=2, REQ0, TX_DATA0=16'h0402, slave loopback MISO=MOSI -> MOSI bits 0000_0100_0000_0010 on trailing edges, RX_DATA=16'h0402, DONE0 at cycle 70.
REQ-037 Modes 1,2,3 same frame -> SCK idle = CKP, 32 edges, RX_DATA=16'h0402 each; CPH=1 samples on trailing edges.
REQ-038 REQ0, REQ1 high together from reset, held -> grants 0,1,0,1; DONE0/DONE1 alternate, never overlap.
REQ-039 MISO tied 1, TX_DATA1=16'h0000 -> RX_DATA=16'hFFFF, MOSI constant 0, DONE1 only.
REQ-040 RESET_N low at edge 10 of SHIFT -> SS=1, SCK=0, BUSY=0 asynchronously; no DONE; held REQ0 restarts full frame after release.
REQ-041 SCK_DIV=1 -> SCK half-period 1 CLK, frame 36 cycles, data correct.
